// File: rtl/mm_seq_pkg.sv
// mm_seq_pkg: shared definitions for the matrix-multiplier run sequencer.
//   STREAM_W    - width of the operand and result AXI-Stream data buses
//   WDOG_W      - width of the stall watchdog counter
//   seq_state_e - sequencer FSM state encoding
//   sat_inc8    - saturating 8-bit increment used by the run counter
package mm_seq_pkg;

    localparam int STREAM_W = 32;
    localparam int WDOG_W   = 20;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_RECV = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } seq_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/mm_seq_watchdog.sv
// mm_seq_watchdog: stall detector for the sequencer's stream phases.
//   clk     - system clock
//   reset   - asynchronous active-high reset
//   enable  - count only while high; the count is held at zero otherwise
//   clear   - restart the count from zero (handshake or state entry)
//   expired - high during the TIMEOUT-th consecutive enabled cycle without a clear
module mm_seq_watchdog
    import mm_seq_pkg::*;
#(
    parameter logic [WDOG_W-1:0] TIMEOUT = 20'd20000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LAST_COUNT = TIMEOUT - WDOG_W'(1);

    logic [WDOG_W-1:0] count_q;

    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values regardless of the order the simulator runs blocks in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear || !enable) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + WDOG_W'(1);
        end
    end

    // Expiry does not look at clear: the caller gives a same-cycle handshake
    // priority, which also keeps this output free of a combinational loop.
    assign expired = enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/mm_run_sequencer.sv
// mm_run_sequencer: drives repeated test runs through the matrix multiplier.
// Each run streams IN_WORDS operand words (value = index + 1), then drains
// OUT_WORDS result words, summing them mod 2^32 and checking TLAST framing.
//   clk, reset         - system clock, asynchronous active-high reset
//   start              - level-sampled; accepted in IDLE, DONE or ERR
//   input_r_T*         - operand AXI-Stream master towards the multiplier
//   output_r_T*        - result AXI-Stream slave from the multiplier
//   busy / done        - in SEND/RECV/GAP / in DONE
//   timeout_err        - sticky watchdog abort
//   tlast_err          - sticky framing error (runs continue)
//   run_count          - completed runs since the last start (saturating)
//   result_sum         - result checksum of the last completed run
module mm_run_sequencer
    import mm_seq_pkg::*;
#(
    parameter int unsigned       IN_WORDS   = 432,
    parameter int unsigned       OUT_WORDS  = 216,
    parameter logic [7:0]        NUM_RUNS   = 8'd4,
    parameter int unsigned       GAP_CYCLES = 16,
    parameter logic [WDOG_W-1:0] TIMEOUT    = 20'd20000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                input_r_TVALID,
    output logic [STREAM_W-1:0] input_r_TDATA,
    output logic                input_r_TLAST,
    input  logic                input_r_TREADY,
    input  logic                output_r_TVALID,
    input  logic [STREAM_W-1:0] output_r_TDATA,
    input  logic                output_r_TLAST,
    output logic                output_r_TREADY,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic                tlast_err,
    output logic [7:0]          run_count,
    output logic [31:0]         result_sum
);

    localparam int IN_IDX_W  = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int OUT_IDX_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IN_IDX_W-1:0]  IN_LAST  = IN_IDX_W'(IN_WORDS - 1);
    localparam logic [OUT_IDX_W-1:0] OUT_LAST = OUT_IDX_W'(OUT_WORDS - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    seq_state_e state_q, state_d;

    logic [IN_IDX_W-1:0]  in_idx_q;
    logic [OUT_IDX_W-1:0] out_idx_q;
    logic [GAP_W-1:0]     gap_cnt_q;
    logic [31:0]          sum_q;
    logic [31:0]          result_sum_q;
    logic [7:0]           run_count_q;
    logic                 timeout_err_q;
    logic                 tlast_err_q;

    logic       in_hs, out_hs, in_last, out_at_last;
    logic       run_end, frame_err, runs_done, start_ok, enter_send;
    logic       wd_enable, wd_clear, wd_expired, wd_fire;
    logic [7:0] run_count_inc;

    // In SEND the operand TVALID is always high and in RECV the result TREADY
    // is always high, so a handshake reduces to the peer's signal.
    assign in_hs       = (state_q == ST_SEND) && input_r_TREADY;
    assign out_hs      = (state_q == ST_RECV) && output_r_TVALID;
    assign in_last     = (in_idx_q == IN_LAST);
    assign out_at_last = (out_idx_q == OUT_LAST);

    // A run ends on TLAST or on the final expected word, whichever comes
    // first; any disagreement between the two is a framing error.
    assign run_end       = out_hs && (output_r_TLAST || out_at_last);
    assign frame_err     = out_hs && (output_r_TLAST != out_at_last);
    assign run_count_inc = sat_inc8(run_count_q);
    assign runs_done     = (NUM_RUNS != 8'd0) && (run_count_inc == NUM_RUNS);

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_ERR));

    assign wd_enable = (state_q == ST_SEND) || (state_q == ST_RECV);
    assign wd_fire   = wd_expired && !in_hs && !out_hs;
    assign wd_clear  = in_hs || out_hs || (state_d != state_q);

    // Word counters and the running sum restart on every entry into SEND,
    // whether from a start command or from the end of a gap.
    assign enter_send = (state_d == ST_SEND) && (state_q != ST_SEND);

    mm_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .enable  (wd_enable),
        .clear   (wd_clear),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d         = state_q;
        input_r_TVALID  = 1'b0;
        input_r_TDATA   = '0;
        input_r_TLAST   = 1'b0;
        output_r_TREADY = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                done = (state_q == ST_DONE);
                if (start) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                busy           = 1'b1;
                input_r_TVALID = 1'b1;
                input_r_TDATA  = STREAM_W'(in_idx_q) + STREAM_W'(1);
                input_r_TLAST  = in_last;
                if (in_hs) begin
                    if (in_last) begin
                        state_d = ST_RECV;
                    end
                end else if (wd_fire) begin
                    state_d = ST_ERR;
                end
            end
            ST_RECV: begin
                busy            = 1'b1;
                output_r_TREADY = 1'b1;
                if (run_end) begin
                    if (runs_done) begin
                        state_d = ST_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (wd_fire) begin
                    state_d = ST_ERR;
                end
            end
            ST_GAP: begin
                busy = 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_idx_q      <= '0;
            out_idx_q     <= '0;
            gap_cnt_q     <= '0;
            sum_q         <= '0;
            result_sum_q  <= '0;
            run_count_q   <= '0;
            timeout_err_q <= 1'b0;
            tlast_err_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                run_count_q   <= '0;
                timeout_err_q <= 1'b0;
                tlast_err_q   <= 1'b0;
            end

            if (enter_send) begin
                in_idx_q  <= '0;
                out_idx_q <= '0;
                sum_q     <= '0;
            end else begin
                if (in_hs && !in_last) begin
                    in_idx_q <= in_idx_q + IN_IDX_W'(1);
                end
                if (out_hs) begin
                    sum_q     <= sum_q + output_r_TDATA;
                    out_idx_q <= out_idx_q + OUT_IDX_W'(1);
                end
            end

            if (run_end) begin
                result_sum_q <= sum_q + output_r_TDATA;
                run_count_q  <= run_count_inc;
            end
            if (frame_err) begin
                tlast_err_q <= 1'b1;
            end
            if (wd_fire) begin
                timeout_err_q <= 1'b1;
            end

            gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + GAP_W'(1) : '0;
        end
    end

    assign timeout_err = timeout_err_q;
    assign tlast_err   = tlast_err_q;
    assign run_count   = run_count_q;
    assign result_sum  = result_sum_q;

endmodule
